// File: rtl/sprite_frame_scheduler.sv
// sprite_frame_scheduler
//   Per-frame controller that shares the single vga_adapter plot port among
//   N_SPRITES sprite drawers. Each frame tick runs an erase pass over the
//   active slots, one move pulse, and then a draw pass over the same slots.
//
//   Optional build macro: SPRITE_SCHED_TIMEOUT_EN
//     When it is defined, a per-slot WAIT watchdog skips any drawer that has
//     not finished within TIMEOUT cycles, and sets the sticky timeout_err port.
//     When it is not defined, there is no watchdog and no timeout_err port.
//
//   Ports
//     clock, resetn            system clock; asynchronous active-low reset
//     frame_tick               one-cycle frame pulse
//     active[N]                per-slot enable, latched at frame start
//     drw_x/y/colour/valid     per-slot pixel stream (slot i at [W*i +: W])
//     drw_done[N]              slot has finished its sprite
//     drw_start[N]             one-hot, one-cycle start pulse to the granted slot
//     erase                    high for the whole erase pass
//     move_en                  one-cycle advance pulse between the passes
//     vga_x/y/colour/plot      registered plot port to vga_adapter
//     busy                     high while a frame is in progress
//     overrun                  sticky: a frame tick was lost
//     timeout_err              sticky watchdog flag (macro builds only)
module sprite_frame_scheduler #(
  parameter int unsigned N_SPRITES    = 4,
  parameter int unsigned IDX_W        = 3,
  parameter logic [2:0]  ERASE_COLOUR = 3'b000,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   frame_tick,
  input  logic [N_SPRITES-1:0]   active,
  input  logic [8*N_SPRITES-1:0] drw_x,
  input  logic [7*N_SPRITES-1:0] drw_y,
  input  logic [3*N_SPRITES-1:0] drw_colour,
  input  logic [N_SPRITES-1:0]   drw_valid,
  input  logic [N_SPRITES-1:0]   drw_done,
  output logic [N_SPRITES-1:0]   drw_start,
  output logic                   erase,
  output logic                   move_en,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   overrun
`ifdef SPRITE_SCHED_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  localparam int unsigned X_W     = 8;
  localparam int unsigned Y_W     = 7;
  localparam int unsigned C_W     = 3;
  localparam int unsigned SCR_W   = 160;
  localparam int unsigned SCR_H   = 120;
  localparam logic        PH_ERASE = 1'b0;
  localparam logic        PH_DRAW  = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPRITES - 1);

  // Reject configurations the index or watchdog cannot represent.
  if (N_SPRITES < 1 || N_SPRITES > 8 || (N_SPRITES - 1) >= (1 << IDX_W) ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("sprite_frame_scheduler: invalid parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_MOVE  = 3'd4
  } state_t;

  state_t                 state, state_n, end_state;
  logic [IDX_W-1:0]       idx, idx_n;
  logic                   phase, phase_n;
  logic [N_SPRITES-1:0]   active_q, active_q_n;
  logic                   pending, pending_n;
  logic                   overrun_n;

  logic                   sel_active, sel_valid, sel_done;
  logic [X_W-1:0]         sel_x;
  logic [Y_W-1:0]         sel_y;
  logic [C_W-1:0]         sel_colour;
  logic                   last, wait_exit;

  logic [N_SPRITES-1:0]   drw_start_d;
  logic                   erase_d, move_en_d, busy_d, plot_d, pos_load;
  logic [C_W-1:0]         colour_d;

  // Slot multiplexer: everything the FSM and plot path need from slot idx.
  always_comb begin
    sel_active = 1'b0;
    sel_valid  = 1'b0;
    sel_done   = 1'b0;
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    for (int i = 0; i < int'(N_SPRITES); i++) begin
      if (idx == IDX_W'(i)) begin
        sel_active = active_q[i];
        sel_valid  = drw_valid[i];
        sel_done   = drw_done[i];
        sel_x      = drw_x[X_W*i +: X_W];
        sel_y      = drw_y[Y_W*i +: Y_W];
        sel_colour = drw_colour[C_W*i +: C_W];
      end
    end
  end

  assign last      = (idx == LAST_IDX);
  assign end_state = (phase == PH_ERASE) ? S_MOVE : S_IDLE;

`ifdef SPRITE_SCHED_TIMEOUT_EN
  // WAIT watchdog: counts cycles spent on the current slot.
  logic [7:0] wdog;
  logic       timeout_hit;

  assign timeout_hit = (state == S_WAIT) && (wdog == 8'(TIMEOUT - 1));
  assign wait_exit   = sel_done | timeout_hit;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      wdog        <= (state == S_WAIT && state_n == S_WAIT) ? wdog + 8'd1 : 8'd0;
      timeout_err <= timeout_err | (timeout_hit & ~sel_done);
    end
  end
`else
  assign wait_exit = sel_done;
`endif

  // State register plus all registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      idx        <= '0;
      phase      <= PH_ERASE;
      active_q   <= '0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      drw_start  <= '0;
      erase      <= 1'b0;
      move_en    <= 1'b0;
      busy       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      phase     <= phase_n;
      active_q  <= active_q_n;
      pending   <= pending_n;
      overrun   <= overrun_n;
      drw_start <= drw_start_d;
      erase     <= erase_d;
      move_en   <= move_en_d;
      busy      <= busy_d;
      vga_plot  <= plot_d;
      if (pos_load) begin
        vga_x      <= sel_x;
        vga_y      <= sel_y;
        vga_colour <= colour_d;
      end
    end
  end

  // Next-state logic and frame-tick bookkeeping.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    phase_n    = phase;
    active_q_n = active_q;
    pending_n  = pending;
    overrun_n  = overrun;

    // A tick that cannot start a frame now is remembered; a second one is lost.
    if (frame_tick) begin
      if (pending)         overrun_n = 1'b1;
      if (state != S_IDLE) pending_n = 1'b1;
    end

    unique case (state)
      S_IDLE: begin
        if (frame_tick || pending) begin
          active_q_n = active;
          idx_n      = '0;
          phase_n    = PH_ERASE;
          pending_n  = 1'b0;
          state_n    = S_SEL;
        end
      end
      S_SEL: begin
        if (sel_active)  state_n = S_START;
        else if (last)   state_n = end_state;
        else             idx_n   = idx + IDX_W'(1);
      end
      S_START: state_n = S_WAIT;
      S_WAIT: begin
        if (wait_exit) begin
          if (last) begin
            state_n = end_state;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = S_SEL;
          end
        end
      end
      S_MOVE: begin
        phase_n = PH_DRAW;
        idx_n   = '0;
        state_n = S_SEL;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output decode; control outputs look ahead at the next state so the
  // registered copies line up with the state they describe.
  always_comb begin
    busy_d      = (state_n != S_IDLE);
    erase_d     = busy_d && (phase_n == PH_ERASE);
    move_en_d   = (state_n == S_MOVE);
    drw_start_d = '0;
    for (int i = 0; i < int'(N_SPRITES); i++) begin
      drw_start_d[i] = (state_n == S_START) && (idx_n == IDX_W'(i));
    end
    pos_load = (state == S_WAIT);
    plot_d   = pos_load && sel_valid &&
               (sel_x < X_W'(SCR_W)) && (sel_y < Y_W'(SCR_H));
    colour_d = (phase == PH_ERASE) ? ERASE_COLOUR : sel_colour;
  end

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Self-checking bench for sprite_frame_scheduler: behavioural drawer models
// feed a plot scoreboard and an ordered start/move event scoreboard.
module tb_sprite_frame_scheduler;

  localparam int N    = 4;
  localparam int NPIX = 13;
  localparam int EV_MOVE = 100;

  logic             clock, resetn, frame_tick;
  logic [N-1:0]     active;
  logic [8*N-1:0]   drw_x;
  logic [7*N-1:0]   drw_y;
  logic [3*N-1:0]   drw_colour;
  logic [N-1:0]     drw_valid, drw_done, drw_start;
  logic             erase, move_en, vga_plot, busy, overrun;
  logic [7:0]       vga_x;
  logic [6:0]       vga_y;
  logic [2:0]       vga_colour;
`ifdef SPRITE_SCHED_TIMEOUT_EN
  logic             timeout_err;
`endif

  sprite_frame_scheduler #(
    .N_SPRITES(N), .IDX_W(3), .ERASE_COLOUR(3'b000), .TIMEOUT(20)
  ) dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .active(active),
    .drw_x(drw_x), .drw_y(drw_y), .drw_colour(drw_colour),
    .drw_valid(drw_valid), .drw_done(drw_done), .drw_start(drw_start),
    .erase(erase), .move_en(move_en), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
    .overrun(overrun)
`ifdef SPRITE_SCHED_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } plot_t;

  plot_t plot_q[$];
  int    ev_q[$];
  int    plot_cnt;
  int    n_checks = 0;
  int    n_fail   = 0;

  // drawer model state
  bit    run[N];
  bit    cur_erase[N];
  bit    hang[N];
  int    pix[N];
  int    start_cnt[N];
  bit    mode_edge;

  plot_t      mon_e;
  int         mon_code;
  logic [7:0] px;
  logic [6:0] py;
  logic [2:0] pc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic ev_match(input int code);
    if (ev_q.size() == 0) check("event_unexpected", 32'(code), 32'd0);
    else                  check("event_order", 32'(code), 32'(ev_q.pop_front()));
  endtask

  function automatic int start_ev(input int slot, input bit er);
    return 16 + (er ? 8 : 0) + slot;
  endfunction

  // Pixel pattern of a drawer; slot 0 can be switched to screen-edge cases.
  task automatic pix_xy(input int s, input int p, output logic [7:0] x, output logic [6:0] y);
    x = 8'(20 * s + p);
    y = 7'(10 * s + p);
    if (mode_edge && s == 0) begin
      case (p)
        0: begin x = 8'hFF; y = 7'h7F; end
        1: begin x = 8'd159; y = 7'd119; end
        2: begin x = 8'd160; y = 7'd5; end
        3: begin x = 8'd5;   y = 7'd120; end
        default: ;
      endcase
    end
  endtask

  // Monitor then drawers, both away from the active edge.
  always @(negedge clock) begin
    if (vga_plot) begin
      plot_cnt++;
      if (plot_q.size() == 0) begin
        check("plot_unexpected", 32'(vga_plot), 32'd0);
      end else begin
        mon_e = plot_q.pop_front();
        check("plot_x", 32'(vga_x), 32'(mon_e.x));
        check("plot_y", 32'(vga_y), 32'(mon_e.y));
        check("plot_colour", 32'(vga_colour), 32'(mon_e.c));
      end
    end
    if (drw_start != '0) begin
      if ($countones(drw_start) != 1) check("start_onehot", 32'($countones(drw_start)), 32'd1);
      mon_code = 0;
      for (int i = 0; i < N; i++) if (drw_start[i]) mon_code = start_ev(i, erase);
      ev_match(mon_code);
    end
    if (move_en) ev_match(EV_MOVE);

    for (int i = 0; i < N; i++) begin
      drw_valid[i] = 1'b0;
      drw_done[i]  = 1'b0;
      if (!resetn) begin
        run[i] = 1'b0; pix[i] = 0; start_cnt[i] = 0;
      end else begin
        if (run[i] && !hang[i]) begin
          if (pix[i] < NPIX) begin
            pix_xy(i, pix[i], px, py);
            pc = 3'(i + 1);
            drw_x[8*i +: 8]      = px;
            drw_y[7*i +: 7]      = py;
            drw_colour[3*i +: 3] = pc;
            drw_valid[i]         = 1'b1;
            if (px < 8'd160 && py < 7'd120)
              plot_q.push_back('{x: px, y: py, c: (cur_erase[i] ? 3'b000 : pc)});
            pix[i]++;
          end else begin
            drw_done[i] = 1'b1;
            run[i]      = 1'b0;
          end
        end
        if (drw_start[i]) begin
          run[i] = 1'b1;
          pix[i] = 0;
          start_cnt[i]++;
          cur_erase[i] = (start_cnt[i] % 2) == 1;
        end
      end
    end
  end

  task automatic pulse_tick();
    @(negedge clock) frame_tick = 1'b1;
    @(negedge clock) frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int quiet = 0;
    int c = 0;
    while (quiet < 3 && c < limit) begin
      @(negedge clock);
      c++;
      if (!busy) quiet++; else quiet = 0;
    end
    if (quiet < 3) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic push_frame(input logic [N-1:0] act);
    for (int i = 0; i < N; i++) if (act[i]) ev_q.push_back(start_ev(i, 1'b1));
    ev_q.push_back(EV_MOVE);
    for (int i = 0; i < N; i++) if (act[i]) ev_q.push_back(start_ev(i, 1'b0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},    32'(busy), 32'd0);
    check({tag, "_erase"},   32'(erase), 32'd0);
    check({tag, "_move"},    32'(move_en), 32'd0);
    check({tag, "_start"},   32'(drw_start), 32'd0);
    check({tag, "_plot"},    32'(vga_plot), 32'd0);
    check({tag, "_x"},       32'(vga_x), 32'd0);
    check({tag, "_y"},       32'(vga_y), 32'd0);
    check({tag, "_colour"},  32'(vga_colour), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  task automatic check_drained(input string tag, input int plots);
    check({tag, "_plot_count"}, 32'(plot_cnt), 32'(plots));
    check({tag, "_events_left"}, 32'(ev_q.size()), 32'd0);
    check({tag, "_plots_left"}, 32'(plot_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    resetn = 1'b0; frame_tick = 1'b0; active = '0; mode_edge = 1'b0;
    drw_x = '0; drw_y = '0; drw_colour = '0; drw_valid = '0; drw_done = '0;
    for (int i = 0; i < N; i++) hang[i] = 1'b0;
    plot_cnt = 0;
    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    resetn = 1'b1;
    repeat (6) @(negedge clock);

    // A: no active slots -> 2N+1 busy cycles, move_en in the middle.
    active = '0;
    ev_q.push_back(EV_MOVE);
    pulse_tick();
    for (int k = 1; k <= 12; k++) begin
      check($sformatf("A_busy_c%0d", k), 32'(busy), 32'(k <= 9));
      check($sformatf("A_move_c%0d", k), 32'(move_en), 32'(k == 5));
      @(negedge clock);
    end
    check_drained("A", 0);

    // B: slots 0 and 2, erase then draw.
    active = 4'b0101; plot_cnt = 0;
    push_frame(active);
    pulse_tick();
    wait_idle("B", 2000);
    check_drained("B", 52);

    // C: screen-edge suppression on slot 0.
    active = 4'b0001; plot_cnt = 0; mode_edge = 1'b1;
    push_frame(active);
    pulse_tick();
    wait_idle("C", 2000);
    check_drained("C", 20);
    mode_edge = 1'b0;

    // D: two extra ticks while busy -> one pending frame, then overrun.
    active = 4'b0001; plot_cnt = 0;
    push_frame(active);
    push_frame(active);
    pulse_tick();
    repeat (4) @(negedge clock);
    pulse_tick();
    check("D_overrun_after_pending", 32'(overrun), 32'd0);
    repeat (4) @(negedge clock);
    pulse_tick();
    check("D_overrun_set", 32'(overrun), 32'd1);
    wait_idle("D", 3000);
    check_drained("D", 52);
    check("D_overrun_sticky", 32'(overrun), 32'd1);

    // E: reset during WAIT of slot 2 aborts; next frame restarts cleanly.
    active = 4'b0101; plot_cnt = 0;
    push_frame(active);
    pulse_tick();
    begin
      int c = 0;
      while (!drw_start[2] && c < 300) begin @(negedge clock); c++; end
    end
    check("E_start2_seen", 32'(drw_start[2]), 32'd1);
    check("E_start2_erase", 32'(erase), 32'd1);
    repeat (3) @(negedge clock);
    #2 resetn = 1'b0;
    #1 check_outputs_zero("E_abort");
    plot_q.delete();
    ev_q.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    plot_cnt = 0;
    push_frame(active);
    pulse_tick();
    check("E_restart_erase", 32'(erase), 32'd1);
    wait_idle("E", 2000);
    check_drained("E", 52);

    // F: slot 1 never finishes.
    active = 4'b0010; plot_cnt = 0; hang[1] = 1'b1;
`ifdef SPRITE_SCHED_TIMEOUT_EN
    check("F_tmo_err_pre", 32'(timeout_err), 32'd0);
    push_frame(active);
    pulse_tick();
    begin
      int bc = 0;
      while (busy && bc < 1000) begin bc++; @(negedge clock); end
      check("F_busy_cycles", 32'(bc), 32'd51);
    end
    check("F_tmo_err", 32'(timeout_err), 32'd1);
    wait_idle("F", 100);
    check_drained("F", 0);
`else
    ev_q.push_back(start_ev(1, 1'b1));
    pulse_tick();
    repeat (300) @(negedge clock);
    check("F_stuck_busy", 32'(busy), 32'd1);
    check("F_stuck_erase", 32'(erase), 32'd1);
    check_drained("F", 0);
`endif
    hang[1] = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
